// File: rtl/package_bus.sv
// package_bus: shared bus types and arbiter constants.
package package_bus;

   typedef enum logic {IDLE, BUSY} t_arb_state;

   localparam int TMO_DEF = 16;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } t_bus;

endpackage

// File: rtl/systemverilog_rr_pick.sv
// systemverilog_rr_pick: combinational round-robin picker, first request after ptr wins.
module systemverilog_rr_pick #(
   parameter int N  = 4,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic          any,
   output logic [GW-1:0] idx
);

   logic [N-1:0] rot;
   int           off;

   // rotating the doubled vector puts requester ptr+1 at bit 0
   always_comb begin
      rot = N'({req, req} >> (int'(ptr) + 1));
      off = 0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) off = i;
      any = |req;
      idx = GW'((int'(ptr) + 1 + off) % N);
   end

endmodule

// File: rtl/systemverilog_bus_arbiter.sv
// systemverilog_bus_arbiter: round-robin arbiter of N valid/ready requesters onto one bus,
// with a bus_rdy timeout that aborts stalled transfers.
module systemverilog_bus_arbiter
   import package_bus::*;
#(
   parameter int N   = 4,
   parameter int TMO = TMO_DEF,
   parameter int GW  = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_vld,
   input  logic [N*32-1:0] req_adr,
   input  logic [N*32-1:0] req_dat,
   output logic [N-1:0]    req_rdy,
   output logic [N-1:0]    req_err,
   output logic            bus_vld,
   output logic [31:0]     bus_adr,
   output logic [31:0]     bus_dat,
   input  logic            bus_rdy,
   output logic [GW-1:0]   gnt_idx
);

   localparam int CW = TMO > 0 ? $clog2(TMO + 1) : 1;

   t_arb_state    state, nxt;
   t_bus          lat;
   logic [GW-1:0] ptr, pidx;
   logic [CW-1:0] cnt;
   logic          any, trn, tmo, done;

   systemverilog_rr_pick #(.N(N), .GW(GW)) u_pick (
      .req(req_vld),
      .ptr(ptr),
      .any(any),
      .idx(pidx)
   );

   assign bus_adr = lat.adr;
   assign bus_dat = lat.dat;

   // a bus_rdy coinciding with expiry wins, so it is a clean completion
   always_comb begin
      trn              = bus_vld & bus_rdy;
      tmo              = TMO != 0 && int'(cnt) == TMO - 1;
      done             = state == BUSY && (trn || tmo);
      nxt              = state == IDLE ? (any ? BUSY : IDLE) : (done ? IDLE : BUSY);
      req_rdy          = '0;
      req_err          = '0;
      req_rdy[gnt_idx] = done;
      req_err[gnt_idx] = done & ~trn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bus_vld <= 1'b0;
         lat     <= '0;
         gnt_idx <= '0;
         ptr     <= GW'(N - 1);
         cnt     <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && any) begin
            bus_vld <= 1'b1;
            lat     <= '{adr: req_adr[32*int'(pidx) +: 32], dat: req_dat[32*int'(pidx) +: 32]};
            gnt_idx <= pidx;
            ptr     <= pidx;
            cnt     <= '0;
         end else if (done)
            bus_vld <= 1'b0;
         else if (state == BUSY && cnt != '1)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_systemverilog_bus_arbiter.sv
// tb_systemverilog_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration model.
module tb_systemverilog_bus_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;
   localparam int GW  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    vld = '0;
   logic [N*32-1:0] adr = '0;
   logic [N*32-1:0] dat = '0;
   logic            brdy = 1'b0;
   logic [N-1:0]    req_rdy, req_err;
   logic            bus_vld;
   logic [31:0]     bus_adr, bus_dat;
   logic [GW-1:0]   gnt_idx;

   int checks = 0;
   int errors = 0;

   // model: owner of the bus, how many stalled cycles it has seen, last winner
   bit          m_busy;
   int          m_gnt, m_ptr, m_age;
   logic [31:0] m_adr, m_dat;

   always #5 clk = ~clk;

   systemverilog_bus_arbiter #(.N(N), .TMO(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .req_vld(vld),
      .req_adr(adr),
      .req_dat(dat),
      .req_rdy(req_rdy),
      .req_err(req_err),
      .bus_vld(bus_vld),
      .bus_adr(bus_adr),
      .bus_dat(bus_dat),
      .bus_rdy(brdy),
      .gnt_idx(gnt_idx)
   );

   function automatic logic [N-1:0] exp_rdy();
      return (m_busy && (brdy || m_age == TMO - 1)) ? N'(1) << m_gnt : '0;
   endfunction

   function automatic logic [N-1:0] exp_err();
      return (m_busy && !brdy && m_age == TMO - 1) ? N'(1) << m_gnt : '0;
   endfunction

   task automatic mdl_reset();
      m_busy = 0; m_gnt = 0; m_ptr = N - 1; m_age = 0; m_adr = '0; m_dat = '0;
   endtask

   task automatic tick();
      logic [N-1:0] v;
      bit           b;
      int           g;
      v = vld;
      b = brdy;
      @(posedge clk);
      #1;
      if (rst) mdl_reset();
      else if (!m_busy) begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         if (g >= 0) begin
            m_busy = 1; m_gnt = g; m_ptr = g; m_age = 0;
            m_adr = adr[32*g +: 32]; m_dat = dat[32*g +: 32];
         end
      end else if (b || m_age == TMO - 1) m_busy = 0;
      else m_age++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = '0;
      brdy = 1'b0;
      mdl_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL reset_bus_vld got %b want 0", bus_vld); end
      checks++; if (bus_adr !== 32'h0) begin errors++; $display("FAIL reset_bus_adr got %h want 0", bus_adr); end
      checks++; if (bus_dat !== 32'h0) begin errors++; $display("FAIL reset_bus_dat got %h want 0", bus_dat); end
      checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d want 0", gnt_idx); end
      checks++; if (req_rdy !== 4'b0 || req_err !== 4'b0) begin errors++; $display("FAIL reset_rdy_err got %b/%b want 0000/0000", req_rdy, req_err); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mdl_reset();
   endtask

   task automatic test_single();
      do_reset();
      vld = 4'b0100;
      adr[64 +: 32] = 32'h100;
      dat[64 +: 32] = 32'hCAFE;
      brdy = 1'b1;
      #1;
      checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", bus_vld); end
      tick();
      checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %b want 1", bus_vld); end
      checks++; if (bus_adr !== 32'h100 || bus_dat !== 32'hCAFE) begin errors++; $display("FAIL single_adr_dat got %h/%h want 100/cafe", bus_adr, bus_dat); end
      checks++; if (req_rdy !== 4'b0100 || req_err !== 4'b0) begin errors++; $display("FAIL single_rdy got %b/%b want 0100/0000", req_rdy, req_err); end
      checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL single_gnt got %0d want 2", gnt_idx); end
      tick();
      vld = '0;
      #1;
      checks++; if (bus_vld !== 1'b0 || bus_adr !== 32'h100) begin errors++; $display("FAIL single_after got %b/%h want 0/100", bus_vld, bus_adr); end
      tick();
   endtask

   task automatic test_all_rr();
      int n;
      int cnt [N];
      n = 0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      do_reset();
      vld = '1;
      brdy = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         checks++; if ((req_rdy != 0) !== (c % 2 == 1)) begin errors++; $display("FAIL rr_pulse cycle %0d got %b want pulse=%0d", c, req_rdy, c % 2); end
         if (req_rdy != 0) begin
            checks++; if (gnt_idx !== GW'(n % N)) begin errors++; $display("FAIL rr_order grant %0d got %0d want %0d", n, gnt_idx, n % N); end
            cnt[gnt_idx]++;
            n++;
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (cnt[i] != 2) begin errors++; $display("FAIL rr_count req %0d got %0d want 2", i, cnt[i]); end
      end
      vld = '0;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      vld = 4'b0011;
      brdy = 1'b0;
      tick();
      for (int c = 1; c <= TMO; c++) begin
         #1;
         checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL tmo_vld cycle %0d got %b want 1", c, bus_vld); end
         checks++; if (req_rdy !== (c == TMO ? 4'b0001 : 4'b0) || req_err !== (c == TMO ? 4'b0001 : 4'b0)) begin
            errors++; $display("FAIL tmo_rdy_err cycle %0d got %b/%b", c, req_rdy, req_err);
         end
         tick();
      end
      vld[0] = 1'b0;
      #1;
      checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL tmo_drop got %b want 0", bus_vld); end
      tick();
      checks++; if (bus_vld !== 1'b1 || gnt_idx !== 2'd1) begin errors++; $display("FAIL tmo_next got %b/%0d want 1/1", bus_vld, gnt_idx); end
      brdy = 1'b1;
      #1;
      checks++; if (req_rdy !== 4'b0010 || req_err !== 4'b0) begin errors++; $display("FAIL tmo_next_rdy got %b/%b want 0010/0000", req_rdy, req_err); end
      tick();
      vld = '0;
      tick();
   endtask

   task automatic test_rdy_at_expiry();
      do_reset();
      vld = 4'b1000;
      tick();
      for (int c = 1; c < TMO; c++) tick();
      brdy = 1'b1;
      #1;
      checks++; if (req_rdy !== 4'b1000 || req_err !== 4'b0) begin errors++; $display("FAIL expiry_rdy got %b/%b want 1000/0000", req_rdy, req_err); end
      tick();
      vld = '0;
      #1;
      checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL expiry_done got %b want 0", bus_vld); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      vld = 4'b0100;
      adr[64 +: 32] = 32'h55;
      adr[0 +: 32] = 32'hA0;
      tick(); tick(); tick();
      checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", bus_vld); end
      rst = 1'b1;
      #1;
      checks++; if (bus_vld !== 1'b0 || req_rdy !== 4'b0 || req_err !== 4'b0) begin errors++; $display("FAIL rstmid_async got %b/%b/%b want 0", bus_vld, req_rdy, req_err); end
      checks++; if (gnt_idx !== 2'd0 || bus_adr !== 32'h0 || bus_dat !== 32'h0) begin errors++; $display("FAIL rstmid_vals got %0d/%h/%h want 0", gnt_idx, bus_adr, bus_dat); end
      vld = '1;
      mdl_reset();
      tick();
      rst = 1'b0;
      tick();
      checks++; if (gnt_idx !== 2'd0 || bus_vld !== 1'b1 || bus_adr !== 32'hA0) begin errors++; $display("FAIL rstmid_first got %0d/%b/%h want 0/1/a0", gnt_idx, bus_vld, bus_adr); end
      vld = '0;
   endtask

   task automatic test_pair_1_3();
      do_reset();
      vld = 4'b1010;
      brdy = 1'b1;
      tick();
      checks++; if (gnt_idx !== 2'd1 || req_rdy !== 4'b0010) begin errors++; $display("FAIL pair_first got %0d/%b want 1/0010", gnt_idx, req_rdy); end
      tick(); tick();
      checks++; if (gnt_idx !== 2'd3 || req_rdy !== 4'b1000) begin errors++; $display("FAIL pair_second got %0d/%b want 3/1000", gnt_idx, req_rdy); end
      tick(); tick();
      checks++; if (gnt_idx !== 2'd1 || req_rdy !== 4'b0010) begin errors++; $display("FAIL pair_third got %0d/%b want 1/0010", gnt_idx, req_rdy); end
      vld = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] last, er, ee, v;
      bit           was;
      int           waits [N];
      last = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      do_reset();
      for (int it = 0; it < 3000; it++) begin
         for (int i = 0; i < N; i++) begin
            if (vld[i] && last[i]) vld[i] = 1'b0;
            else if (!vld[i] && $urandom % 3 == 0) begin
               vld[i] = 1'b1;
               adr[32*i +: 32] = $urandom;
               dat[32*i +: 32] = $urandom;
            end
         end
         brdy = ((it / 300) % 2 == 1) ? ($urandom % 20 == 0) : ($urandom % 2 == 0);
         #1;
         er = exp_rdy();
         ee = exp_err();
         checks++; if (bus_vld !== m_busy || gnt_idx !== GW'(m_gnt)) begin errors++; $display("FAIL rnd_vld_gnt it %0d got %b/%0d want %b/%0d", it, bus_vld, gnt_idx, m_busy, m_gnt); end
         checks++; if (bus_adr !== m_adr || bus_dat !== m_dat) begin errors++; $display("FAIL rnd_adr_dat it %0d got %h/%h want %h/%h", it, bus_adr, bus_dat, m_adr, m_dat); end
         checks++; if (req_rdy !== er || req_err !== ee) begin errors++; $display("FAIL rnd_rdy_err it %0d got %b/%b want %b/%b", it, req_rdy, req_err, er, ee); end
         last = er;
         was = m_busy;
         v = vld;
         tick();
         if (!was && m_busy) begin
            for (int i = 0; i < N; i++) waits[i] = (i == m_gnt || !v[i]) ? 0 : waits[i] + 1;
            for (int i = 0; i < N; i++) begin
               checks++; if (waits[i] > N - 1) begin errors++; $display("FAIL rnd_fair req %0d waited %0d grants want <= %0d", i, waits[i], N - 1); end
            end
         end
      end
      vld = '0;
   endtask

   initial begin
      mdl_reset();
      test_reset();
      test_single();
      test_all_rr();
      test_timeout();
      test_rdy_at_expiry();
      test_reset_mid();
      test_pair_1_3();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
